// File: rtl/mul_div_ctrl.sv
// mul_div_ctrl: sequencer for the RV32M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide, one iteration per cycle,
// with sign correction and result selection in a dedicated final cycle.
module mul_div_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int RADDR_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [2:0]             op_i,
    input  logic [DATA_WIDTH-1:0]  op1_i,
    input  logic [DATA_WIDTH-1:0]  op2_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   flush_i,
    output logic                   busy_o,
    output logic                   stall_o,
    output logic                   done_o,
    output logic [DATA_WIDTH-1:0]  result_o,
    output logic                   reg_we_o,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [W-1:0]     MIN_NEG  = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_CORR, S_DONE} state_t;

    state_t state_q, state_d;

    logic [2:0]             op_q;
    logic [RADDR_WIDTH-1:0] rd_q;
    logic [2*W-1:0]         a_q;      // multiplicand (shifted left) / dividend in low half
    logic [W-1:0]           b_q;      // multiplier (shifted right) / divisor
    logic [2*W-1:0]         acc_q;    // product, or {remainder, quotient}
    logic [CNT_W-1:0]       count_q;
    logic                   neg_res_q;  // product / quotient needs negation
    logic                   neg_rem_q;  // remainder needs negation
    logic [W-1:0]           result_q;

    logic           launch;
    logic           op1_sgn, op2_sgn, sign1, sign2;
    logic           div_zero, div_ovf, special;
    logic [W-1:0]   special_res;
    logic [W:0]     rem_shift, rem_diff;
    logic           q_bit;
    logic [W-1:0]   rem_next;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo, rem, corr_res;

    // Two's-complement magnitude of an operand when it is treated as signed.
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic is_signed);
        return (is_signed && v[W-1]) ? -v : v;
    endfunction

    // Conditional negation at full product width.
    function automatic logic [2*W-1:0] negate_wide(input logic [2*W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Conditional negation at operand width.
    function automatic logic [W-1:0] negate_word(input logic [W-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Decode the incoming request: operand signedness and divide special cases.
    always_comb begin
        launch      = start_i && !flush_i;
        op1_sgn     = op_i[2] ? !op_i[0] : (op_i[1:0] != 2'b11);
        op2_sgn     = op_i[2] ? !op_i[0] : !op_i[1];
        sign1       = op1_sgn && op1_i[W-1];
        sign2       = op2_sgn && op2_i[W-1];
        div_zero    = op_i[2] && (op2_i == '0);
        div_ovf     = op_i[2] && !op_i[0] && (op1_i == MIN_NEG) && (op2_i == '1);
        special     = div_zero || div_ovf;
        special_res = '0;
        if (div_zero)
            special_res = op_i[1] ? op1_i : '1;
        else if (div_ovf)
            special_res = op_i[1] ? '0 : MIN_NEG;
    end

    // One restoring-divide step and the final correction/selection logic.
    always_comb begin
        rem_shift = {acc_q[2*W-1:W], a_q[W-1]};
        rem_diff  = rem_shift - {1'b0, b_q};
        q_bit     = !rem_diff[W];
        rem_next  = q_bit ? rem_diff[W-1:0] : rem_shift[W-1:0];
        prod      = negate_wide(acc_q, neg_res_q);
        quo       = negate_word(acc_q[W-1:0], neg_res_q);
        rem       = negate_word(acc_q[2*W-1:W], neg_rem_q);
        case (op_q)
            3'b000:                 corr_res = prod[W-1:0];
            3'b001, 3'b010, 3'b011: corr_res = prod[2*W-1:W];
            3'b100, 3'b101:         corr_res = quo;
            default:                corr_res = rem;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (launch) state_d = special ? S_DONE : S_CALC;
            S_CALC: if (count_q == CNT_LAST) state_d = S_CORR;
            S_CORR: state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    // Operand latch, iteration datapath and result register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q      <= '0;
            rd_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (launch) begin
                    op_q      <= op_i;
                    rd_q      <= reg_waddr_i;
                    a_q       <= {{W{1'b0}}, magnitude(op1_i, op1_sgn)};
                    b_q       <= magnitude(op2_i, op2_sgn);
                    acc_q     <= '0;
                    count_q   <= '0;
                    neg_res_q <= sign1 ^ sign2;
                    neg_rem_q <= sign1;
                    if (special) result_q <= special_res;
                end
                S_CALC: begin
                    count_q <= count_q + CNT_W'(1);
                    a_q     <= a_q << 1;
                    if (op_q[2]) begin
                        acc_q <= {rem_next, acc_q[W-2:0], q_bit};
                    end else begin
                        if (b_q[0]) acc_q <= acc_q + a_q;
                        b_q <= b_q >> 1;
                    end
                end
                S_CORR: result_q <= corr_res;
                default: ;
            endcase
        end
    end

    // Outputs: result and rd are only presented during the write-back cycle.
    always_comb begin
        busy_o      = (state_q != S_IDLE);
        stall_o     = ((state_q == S_IDLE) && launch) || (state_q == S_CALC) || (state_q == S_CORR);
        done_o      = (state_q == S_DONE) && !flush_i;
        reg_we_o    = done_o;
        result_o    = done_o ? result_q : '0;
        reg_waddr_o = done_o ? rd_q : '0;
    end

endmodule
